// File: rtl/core_if_ifu.sv
// Instruction fetch unit: one outstanding memory request, a single-entry output
// buffer toward decode, and redirect handling that drops stale responses.
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif

module core_if_ifu #(
    parameter logic [`CORE_PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_redirect,
    input  logic [`CORE_PC_WIDTH-1:0]   i_redirect_pc,
    output logic                        o_ifu_req_valid,
    input  logic                        i_ifu_req_ready,
    output logic [`CORE_PC_WIDTH-1:0]   o_ifu_req_addr,
    input  logic                        i_ifu_rsp_valid,
    input  logic [`CORE_INST_WIDTH-1:0] i_ifu_rsp_inst,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic [`CORE_PC_WIDTH-1:0]   o_pc,
    output logic [`CORE_INST_WIDTH-1:0] o_inst
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FULL = 2'd3
    } state_t;

    state_t                       state, state_nxt;
    logic [`CORE_PC_WIDTH-1:0]    pc_reg, pc_nxt;
    logic [`CORE_PC_WIDTH-1:0]    out_pc, out_pc_nxt;
    logic [`CORE_INST_WIDTH-1:0]  out_inst, out_inst_nxt;
    logic                         drop, drop_nxt;
    logic [`CORE_PC_WIDTH-1:0]    redirect_target;
    logic                         redirect_lsb_unused;

    // Fetch addresses are always word aligned; the low target bits are dropped.
    assign redirect_target     = {i_redirect_pc[`CORE_PC_WIDTH-1:2], 2'b00};
    assign redirect_lsb_unused = ^i_redirect_pc[1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nxt    = state;
        pc_nxt       = pc_reg;
        out_pc_nxt   = out_pc;
        out_inst_nxt = out_inst;
        drop_nxt     = drop;

        unique case (state)
            ST_RST: begin
                state_nxt = ST_REQ;
                if (i_redirect) pc_nxt = redirect_target;
            end
            ST_REQ: begin
                if (i_redirect) begin
                    pc_nxt = redirect_target;
                    // The old-address request still went out; its response must be discarded.
                    if (i_ifu_req_ready) begin
                        state_nxt = ST_WAIT;
                        drop_nxt  = 1'b1;
                    end
                end else if (i_ifu_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_redirect) begin
                    pc_nxt = redirect_target;
                    if (i_ifu_rsp_valid) begin
                        state_nxt = ST_REQ;
                        drop_nxt  = 1'b0;
                    end else begin
                        drop_nxt  = 1'b1;
                    end
                end else if (i_ifu_rsp_valid) begin
                    if (drop) begin
                        state_nxt = ST_REQ;
                        drop_nxt  = 1'b0;
                    end else begin
                        state_nxt    = ST_FULL;
                        out_pc_nxt   = pc_reg;
                        out_inst_nxt = i_ifu_rsp_inst;
                        pc_nxt       = pc_reg + `CORE_PC_WIDTH'(4);
                    end
                end
            end
            ST_FULL: begin
                if (i_redirect) begin
                    pc_nxt    = redirect_target;
                    state_nxt = ST_REQ;
                end else if (ready_out) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= ST_RST;
            pc_reg   <= RESET_PC;
            out_pc   <= '0;
            out_inst <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_reg   <= pc_nxt;
            out_pc   <= out_pc_nxt;
            out_inst <= out_inst_nxt;
            drop     <= drop_nxt;
        end
    end

    assign o_ifu_req_valid = (state == ST_REQ);
    assign o_ifu_req_addr  = pc_reg;
    assign valid_out       = (state == ST_FULL) & ~i_redirect;
    assign o_pc            = out_pc;
    assign o_inst          = out_inst;

endmodule

// File: doc/core_if_ifu.md
CORE_IF_IFU -- requirements
Module: core_if_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, meaning: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_redirect  input  1  flush request from branch/jump resolution.
REQ-005 i_redirect_pc  input  `CORE_PC_WIDTH  new fetch target, valid when i_redirect=1.
REQ-006 o_ifu_req_valid  output  1  instruction memory request valid.
REQ-007 i_ifu_req_ready  input  1  instruction memory request accepted.
REQ-008 o_ifu_req_addr  output  `CORE_PC_WIDTH  fetch address, word aligned.
REQ-009 i_ifu_rsp_valid  input  1  instruction memory response valid, no backpressure.
REQ-010 i_ifu_rsp_inst  input  `CORE_INST_WIDTH  fetched instruction word.
REQ-011 valid_out  output  1  instruction available to decode stage.
REQ-012 ready_out  input  1  decode stage accepts instruction.
REQ-013 o_pc  output  `CORE_PC_WIDTH  PC of presented instruction.
REQ-014 o_inst  output  `CORE_INST_WIDTH  presented instruction.

Function
REQ-015 FSM states SHALL be RST, REQ, WAIT, FULL; at most one memory request outstanding.
REQ-016 Internal regs: pc_reg (next fetch PC), out_pc, out_inst, drop flag.
REQ-017 RST: no request, valid_out=0; next cycle -> REQ.
REQ-018 REQ: o_ifu_req_valid=1, o_ifu_req_addr=pc_reg; on i_ifu_req_ready=1 -> WAIT, else hold with stable addr.
REQ-019 WAIT: on i_ifu_rsp_valid with drop=0: out_inst<=i_ifu_rsp_inst, out_pc<=pc_reg, pc_reg<=pc_reg+4, -> FULL.
REQ-020 WAIT: on i_ifu_rsp_valid with drop=1: discard response, clear drop, -> REQ.
REQ-021 FULL: valid_out=1, o_pc/o_inst stable until handshake; on ready_out=1 -> REQ.
REQ-022 valid_out SHALL equal (state==FULL) & ~i_redirect; o_pc=out_pc, o_inst=out_inst.
REQ-023 o_ifu_req_valid SHALL be 0 in all states except REQ; i_ifu_rsp_valid ignored outside WAIT.
REQ-024 pc_reg+4 SHALL wrap modulo 2^`CORE_PC_WIDTH; carry discarded.
REQ-025 Redirect has priority over all other transitions; pc_reg<={i_redirect_pc[msb:2],2'b00}.
REQ-026 Redirect in REQ without req handshake: -> REQ, next request uses new target.
REQ-027 Redirect in REQ with simultaneous req handshake: -> WAIT with drop=1.
REQ-028 Redirect in WAIT without response: drop<=1, stay WAIT; with response same cycle: discard, drop=0, -> REQ.
REQ-029 Redirect in FULL: discard buffered inst, no handshake occurs that cycle, -> REQ.
REQ-030 Redirect in RST: pc_reg<=target, -> REQ.
REQ-031 Latency: req accept cycle N, response N+k -> valid_out at N+k+1; back-to-back decode ready gives one inst per (k+2) cycles, k>=1.

Reset
REQ-032 On rst_n=0 at clock edge: state=RST, pc_reg=RESET_PC, out_pc=0, out_inst=0, drop=0.
REQ-033 During and one cycle after reset: valid_out=0, o_ifu_req_valid=0.
REQ-034 Reset mid-WAIT abandons the outstanding request; memory SHALL be reset by the same rst_n.
REQ-035 Reset dominates redirect and all handshakes in the same cycle.

Verification
REQ-036 Reset release, req_ready=1, rsp 1 cycle later inst=32'h0000_0013, ready_out=1 -> o_pc=32'h8000_0000, o_inst=32'h13, next req addr 32'h8000_0004.
REQ-037 ready_out=0 for 5 cycles in FULL -> valid_out held 1, o_pc/o_inst unchanged, no new request issued.
REQ-038 Redirect to 32'h8000_0102 in WAIT, rsp arrives 2 cycles later -> rsp discarded, valid_out stays 0, next req addr 32'h8000_0100.
REQ-039 Redirect in FULL with ready_out=1 same cycle -> valid_out=0 that cycle, next req addr = target.
REQ-040 pc_reg=32'hFFFF_FFFC fetch completes -> next req addr 32'h0000_0000.
REQ-041 rst_n=0 while WAIT, late rsp_valid after release -> ignored, first req addr 32'h8000_0000.
